mult4_ex_unit: RTL and testbench
================================

// Module: mult4_ex_unit
// PURPOSE
//  Multi-cycle integer multiplier in the EX stage of the 5-stage hazard-aware pipeline.
//  - Consumes operands from the ID/EX pipeline register.
//  - Drives the stall request that the hazard unit turns into en/flush of the
//    IF/ID, ID/EX and EX/MEM flush-capable registers.
//  - Produces the full 2*DATA_W product over N_CYCLES shift-add iterations,
//    then releases the stall for exactly one cycle so the instruction advances.
// PARAMETERS
//  DATA_W    32  operand width; must be divisible by N_CYCLES
//  N_CYCLES  4   accumulation iterations; DATA_W/N_CYCLES multiplier bits retired per cycle
// PORTS
//  clk        in   1         rising-edge clock
//  arst_n     in   1         asynchronous, active-low reset
//  start      in   1         ID/EX holds a multiply; stays high while stalled
//  is_signed  in   1         1: two's-complement operands, 0: unsigned
//  flush      in   1         synchronous abort, e.g. branch mispredict
//  op_a       in   DATA_W    multiplicand
//  op_b       in   DATA_W    multiplier
//  stall      out  1         hold upstream pipeline registers (en=0)
//  busy       out  1         FSM not in IDLE
//  done       out  1         one-cycle pulse, result valid
//  result     out  2*DATA_W  product, held until the next completion
// BEHAVIOUR
//  Reset (arst_n=0, async): state=IDLE, cnt=0, accumulator=0, result=0, done=0, busy=0.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE, start=1:
//   - latch |op_a|, |op_b| (magnitudes if is_signed) and neg = sign(a)^sign(b)&is_signed
//   - clear accumulator, cnt=0, go to BUSY.
//  BUSY, each cycle:
//   - acc += (mcand * chunk) << (cnt*DATA_W/N_CYCLES), where chunk is the next
//     DATA_W/N_CYCLES bits of the multiplier, LSB first; cnt++
//   - when cnt==N_CYCLES-1: register result = neg ? -acc_final : acc_final, go to DONE.
//  DONE: done=1 for one cycle; unconditionally return to IDLE, even if start is still high.
//   start is ignored in DONE, so the same instruction is never re-issued.
//  stall = (IDLE & start & ~flush) | BUSY; it is combinational so the first cycle
//   stalls immediately. stall=0 in DONE.
//  Latency: N_CYCLES+1 stall cycles (5 by default); result valid in the DONE cycle.
//  Throughput: back-to-back multiplies are accepted in the IDLE cycle that follows DONE.
//  Arithmetic:
//   - accumulation is unsigned on 2*DATA_W bits with no overflow, since magnitude < 2^(2*DATA_W).
//   - -2^(DATA_W-1) magnitude is 2^(DATA_W-1) and is representable unsigned.
//   - final negate is 2*DATA_W two's complement.
//  flush (sync) has priority over start and over the BUSY/DONE progression:
//   - next state=IDLE, cnt=0, done=0; result keeps its old value.
//   - stall=0 in the flush cycle.
//  Reset mid-operation: async return to the reset values; no partial result is retained.
//  Operands are sampled only in the IDLE->BUSY cycle; later changes on op_a/op_b are ignored.
// STRUCTURE
//  Shared package (mult_pkg.vh):
//   - state encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2
//   - CHUNK_W = DATA_W/N_CYCLES
//   - CNT_W = clog2(N_CYCLES)
//  Sub-module mult_chunk_step: combinational (mcand, chunk, cnt, acc_in) -> acc_out.
//   This is the only arithmetic; the top level holds the FSM and registers.
//  The parent instantiates the unit beside the ID/EX register; the hazard unit ORs
//   stall into the en/flush logic: ID/EX en=0, EX/MEM flush=1 while stalled.
// TESTING
//  1. Unsigned: start=1, a=7, b=6, held -> stall=1 for 5 cycles, done pulse, result=42.
//  2. Signed: a=-3 (0xFFFFFFFD), b=5, is_signed=1 -> result=64'hFFFF_FFFF_FFFF_FFF1.
//  3. Extremes: a=b=0xFFFFFFFF, unsigned -> 64'hFFFF_FFFE_0000_0001;
//     signed -> result=1.
//  4. Signed extreme: a=0x80000000, b=0x80000000, signed -> 64'h4000_0000_0000_0000.
//  5. Flush in the 3rd BUSY cycle:
//     - expect: stall=0 that cycle, IDLE next, no done, result unchanged from the prior op.
//     - then 2*3 -> 6.
//  6. Back-to-back: two multiplies with start held across the DONE cycle
//     - expect: exactly two done pulses 6 cycles apart.
//     - expect: correct results; async reset asserted mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/mult4_ex_unit_pkg.sv
// Shared types and widths for the EX-stage multi-cycle multiplier.
package mult4_ex_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned N_CYCLES = 4;
  localparam int unsigned CHUNK_W  = DATA_W / N_CYCLES;
  localparam int unsigned CNT_W    = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
  localparam int unsigned ACC_W    = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Absolute value; the most negative input maps to 2^(DATA_W-1), still exact unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult4_ex_unit_if.sv
// Operand/result/stall bundle between the ID/EX stage and the multiplier.
interface mult4_ex_unit_if;
  import mult4_ex_unit_pkg::*;

  logic                start;
  logic                is_signed;
  logic                flush;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                stall;
  logic                busy;
  logic                done;
  logic [ACC_W-1:0]    result;

  modport master (
    output start, is_signed, flush, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, is_signed, flush, op_a, op_b,
    output stall, busy, done, result
  );

endinterface

// File: rtl/mult4_ex_unit_chunk_step.sv
// One shift-add iteration: adds mcand*chunk, aligned to chunk position cnt, into the accumulator.
module mult4_ex_unit_chunk_step
  import mult4_ex_unit_pkg::*;
(
  input  logic [DATA_W-1:0]  mcand,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic [CNT_W-1:0]   cnt,
  input  logic [ACC_W-1:0]   acc_in,
  output logic [ACC_W-1:0]   acc_out
);

  logic [ACC_W-1:0] partial;

  always_comb begin
    partial = ACC_W'(mcand) * ACC_W'(chunk);
    acc_out = acc_in + (partial << (32'(cnt) * CHUNK_W));
  end

endmodule

// File: rtl/mult4_ex_unit.sv
// EX-stage multi-cycle multiplier: IDLE/BUSY/DONE control, operand latches and result register.
module mult4_ex_unit
  import mult4_ex_unit_pkg::*;
(
  input  logic           clk,
  input  logic           arst_n,
  mult4_ex_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               stall_c;
  logic [ACC_W-1:0]   step_acc;

  // Multiplier is consumed LSB-first by shifting it down one chunk per iteration.
  mult4_ex_unit_chunk_step u_step (
    .mcand   (mcand_q),
    .chunk   (mplier_q[CHUNK_W-1:0]),
    .cnt     (cnt_q),
    .acc_in  (acc_q),
    .acc_out (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    result_d = result_q;
    stall_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          stall_c  = 1'b1;
          mcand_d  = magnitude(bus.op_a, bus.is_signed);
          mplier_d = magnitude(bus.op_b, bus.is_signed);
          neg_d    = (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]) & bus.is_signed;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall_c  = 1'b1;
          acc_d    = step_acc;
          mplier_d = mplier_q >> CHUNK_W;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_CYCLES - 1)) begin
            result_d = neg_q ? -step_acc : step_acc;
            cnt_d    = '0;
            state_d  = ST_DONE;
          end
        end
      end
      // start is ignored here so the held instruction is not issued twice
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.stall  = stall_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult4_ex_unit.sv
// Scoreboard bench for mult4_ex_unit: directed multiplies, flush, back-to-back and async reset.
module tb_mult4_ex_unit;

  logic clk;
  logic arst_n;
  int   cyc = 0;

  mult4_ex_unit_if bus ();

  mult4_ex_unit dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_count = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected product.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got result %h with no expected entry", bus.result);
        end else begin
          check("result", bus.result, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp);
    int n_stall;
    exp_q.push_back(exp);
    last_res = exp;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.is_signed = sgn;
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) break;
      n_stall++;
      @(posedge clk); #1;
      bus.op_a = ~a; bus.op_b = ~b;
    end
    check({name, "_stall_cycles"}, 64'(n_stall), 64'd5);
    check({name, "_done_pulse"}, 64'(bus.done), 64'd1);
    check({name, "_busy_in_done"}, 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int d0, c1, c2;
    arst_n = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.flush = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    #12;
    check("rst_result", bus.result, 64'd0);
    check("rst_done",   64'(bus.done), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_stall",  64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    do_mul("u7x6",    32'd7,          32'd6,          1'b0, 64'd42);
    do_mul("s_m3x5",  32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    do_mul("u_max2",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001);
    do_mul("s_m1sq",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'd1);
    do_mul("s_min2",  32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000);
    do_mul("s_minx1", 32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000);
    do_mul("s_5xm7",  32'd5,          32'hFFFF_FFF9,  1'b1, 64'hFFFF_FFFF_FFFF_FFDD);

    // Flush in the third BUSY cycle
    d0 = done_count;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.is_signed = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("flush_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 64'(bus.busy), 64'd0);
    check("flush_result_kept", bus.result, last_res);
    repeat (6) @(negedge clk);
    check("flush_no_done", 64'(done_count - d0), 64'd0);
    do_mul("u2x3", 32'd2, 32'd3, 1'b0, 64'd6);

    // Back-to-back with start held across DONE
    d0 = done_count;
    c1 = -1; c2 = -1;
    exp_q.push_back(64'd12);
    exp_q.push_back(64'd25);
    last_res = 64'd25;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.is_signed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin c1 = cyc; break; end
    end
    bus.op_a = 32'd5; bus.op_b = 32'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin c2 = cyc; break; end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_done_count", 64'(done_count - d0), 64'd2);
    check("b2b_spacing", 64'(c2 - c1), 64'd6);

    // Async reset in the middle of BUSY
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    check("arst_stall",  64'(bus.stall), 64'd0);
    check("arst_busy",   64'(bus.busy), 64'd0);
    check("arst_done",   64'(bus.done), 64'd0);
    check("arst_result", bus.result, 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    do_mul("u_2p16sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
